// File: rtl/wb_host_pkg.sv
// Shared types for the single-outstanding Wishbone classic host: FSM states,
// command register layout, bus widths and timeout counter width.
package wb_host_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;
  localparam int TMO_CW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic               we;
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
    logic [WB_SELW-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wb_host_timer.sv
// Bus-cycle watchdog: counts stalled cycles from a clear, flags expiry when the
// count reaches LIMIT-1 (combinational), 1-cycle update, no backpressure.
module wb_host_timer
  import wb_host_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == TMO_CW'(LIMIT - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: cmd -> one bus cycle -> rsp, min 2-cycle latency,
// rsp held until rsp_ready_i with cmd_ready_o low; WB_HOST_MASTER_TIMEOUT_EN adds an ack timeout.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [WB_AW-1:0]   cmd_adr_i,
  input  logic [WB_DW-1:0]   cmd_dat_i,
  input  logic [WB_SELW-1:0] cmd_sel_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t           state_q, state_d;
  cmd_t             cmd_q;
  logic [WB_DW-1:0] rsp_dat_q;
  logic             accept;
  logic             bus_ack;
  logic             tmo_hit;

  assign accept  = (state_q == IDLE) && cmd_valid_i;
  assign bus_ack = (state_q == BUS) && wbm_ack_i;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  logic tmo_expired;
  logic rsp_err_q;

  wb_host_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (accept),
    .enable  ((state_q == BUS) && !wbm_ack_i),
    .expired (tmo_expired)
  );

  // An ack in the expiry cycle takes priority over the abort.
  assign tmo_hit = (state_q == BUS) && !wbm_ack_i && tmo_expired;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (bus_ack) begin
      rsp_err_q <= 1'b0;
    end else if (tmo_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign tmo_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i)           state_d = BUS;
      BUS:     if (wbm_ack_i || tmo_hit)  state_d = RESP;
      RESP:    if (rsp_ready_i)           state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rsp_dat_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
      end
      if (bus_ack) begin
        rsp_dat_q <= cmd_q.we ? '0 : wbm_dat_i;
      end else if (tmo_hit) begin
        rsp_dat_q <= '0;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;

  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = cmd_q.we;
  assign wbm_sel_o = cmd_q.sel;
  assign wbm_adr_o = cmd_q.adr;
  assign wbm_dat_o = cmd_q.dat;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master; timeout cases run when WB_HOST_MASTER_TIMEOUT_EN is defined.
module tb_wb_host_master;

  localparam int          TMO = 8;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_wdat, wbm_rdat;
  logic        ack_force, auto_ack;
  logic [31:0] slave_dat;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Zero-wait slave in auto mode returns address ^ XK; otherwise the bench drives ack/data.
  assign wbm_ack  = ack_force | (auto_ack & wbm_stb);
  assign wbm_rdat = auto_ack ? (wbm_adr ^ XK) : slave_dat;

  wb_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_wdat),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_rdat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cmd_set(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first BUS cycle.
  task automatic accept_one(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
    cmd_set(we, adr, dat, sel);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          acc [4];
    logic [31:0] rsps[4];
    int          k, nr, cnt, bad;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack_force = 1'b0; auto_ack = 1'b0; slave_dat = '0;
    repeat (2) @(negedge clk);

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_cyc",       32'(wbm_cyc),   32'd0);
    check("rst_stb",       32'(wbm_stb),   32'd0);
    check("rst_we",        32'(wbm_we),    32'd0);
    check("rst_sel",       32'(wbm_sel),   32'd0);
    check("rst_adr",       wbm_adr,        32'd0);
    check("rst_wdat",      wbm_wdat,       32'd0);
    check("rst_rsp_dat",   rsp_dat,        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stray ack while idle
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("stray_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_ack_cmd_ready", 32'(cmd_ready), 32'd1);
    check("stray_ack_cyc",       32'(wbm_cyc),   32'd0);

    // Write, ack on first stb cycle
    accept_one(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    check("wr_cyc", 32'(wbm_cyc), 32'd1);
    check("wr_stb", 32'(wbm_stb), 32'd1);
    check("wr_we",  32'(wbm_we),  32'd1);
    check("wr_adr", wbm_adr,      32'h3000_0004);
    check("wr_dat", wbm_wdat,     32'hDEAD_BEEF);
    check("wr_sel", 32'(wbm_sel), 32'hF);
    check("wr_cmd_ready_bus", 32'(cmd_ready), 32'd0);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("wr_cyc_after_ack", 32'(wbm_cyc),   32'd0);
    check("wr_rsp_valid",     32'(rsp_valid), 32'd1);
    check("wr_rsp_err",       32'(rsp_err),   32'd0);
    check("wr_rsp_dat",       rsp_dat,        32'd0);
    release_rsp();
    check("wr_back_idle", 32'(cmd_ready), 32'd1);

    // Read with 3 wait states
    slave_dat = 32'h1234_5678;
    accept_one(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    cnt = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wbm_stb) cnt++;
      if (cmd_ready) bad++;
      if (i == 3) ack_force = 1'b1;
      @(negedge clk);
    end
    ack_force = 1'b0;
    check("rd_stb_cycles",   32'(cnt),       32'd4);
    check("rd_cmd_ready_bus", 32'(bad),      32'd0);
    check("rd_stb_after",    32'(wbm_stb),   32'd0);
    check("rd_cmd_ready_rsp", 32'(cmd_ready), 32'd0);
    check("rd_rsp_valid",    32'(rsp_valid), 32'd1);
    check("rd_rsp_dat",      rsp_dat,        32'h1234_5678);
    check("rd_rsp_err",      32'(rsp_err),   32'd0);
    release_rsp();

    // Back-to-back reads, zero-wait slave, rsp_ready tied high
    auto_ack = 1'b1; rsp_ready = 1'b1;
    k = 0; nr = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid && nr < 4) begin
        rsps[nr] = rsp_dat;
        nr++;
      end
      if (k < 4) begin
        cmd_set(1'b0, 32'h3000_0010 + 32'(4 * k), 32'h0, 4'hF);
        if (cmd_ready) begin
          acc[k] = c;
          k++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("b2b_accepts",   32'(k),  32'd4);
    check("b2b_responses", 32'(nr), 32'd4);
    for (int j = 1; j < 4; j++) check("b2b_spacing", 32'(acc[j] - acc[j-1]), 32'd3);
    for (int j = 0; j < 4; j++) check("b2b_rsp_order", rsps[j], (32'h3000_0010 + 32'(4 * j)) ^ XK);

    // Response backpressure with a new command waiting
    accept_one(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    @(negedge clk);
    check("bp_rsp_dat", rsp_dat, 32'h3000_0040 ^ XK);
    cmd_set(1'b1, 32'h3000_0050, 32'h1111_2222, 4'h3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== (32'h3000_0040 ^ XK) || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) bad++;
      @(negedge clk);
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_we",  32'(wbm_we),  32'd1);
    check("bp_next_adr", wbm_adr,      32'h3000_0050);
    check("bp_next_sel", 32'(wbm_sel), 32'h3);
    @(negedge clk);
    check("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_rsp_dat",   rsp_dat,        32'd0);
    @(negedge clk);
    rsp_ready = 1'b0; auto_ack = 1'b0;

    // Reset in the middle of a bus cycle
    accept_one(1'b1, 32'h3000_0060, 32'h5555_AAAA, 4'hF);
    check("rstmid_cyc_before", 32'(wbm_cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_cyc",       32'(wbm_cyc),   32'd0);
    check("rstmid_stb",       32'(wbm_stb),   32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_no_rsp",    32'(rsp_valid), 32'd0);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    // Slave never acks
    accept_one(1'b0, 32'h3000_0070, 32'h0, 4'hF);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wbm_cyc) break;
      cnt++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", 32'(cnt),       32'(TMO));
    check("tmo_rsp_valid",  32'(rsp_valid), 32'd1);
    check("tmo_rsp_err",    32'(rsp_err),   32'd1);
    check("tmo_rsp_dat",    rsp_dat,        32'd0);
    release_rsp();

    // Ack on the last allowed cycle wins over the timeout
    slave_dat = 32'hCAFE_F00D;
    accept_one(1'b0, 32'h3000_0074, 32'h0, 4'hF);
    cnt = 0;
    for (int i = 0; i < TMO; i++) begin
      if (wbm_stb) cnt++;
      if (i == TMO - 1) ack_force = 1'b1;
      @(negedge clk);
    end
    ack_force = 1'b0;
    check("tmo_ack_stb_cycles", 32'(cnt),       32'(TMO));
    check("tmo_ack_rsp_valid",  32'(rsp_valid), 32'd1);
    check("tmo_ack_rsp_err",    32'(rsp_err),   32'd0);
    check("tmo_ack_rsp_dat",    rsp_dat,        32'hCAFE_F00D);
    release_rsp();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Single-outstanding Wishbone classic initiator driving the wbs_* slave port of the SHA1 user-project wrapper. It accepts read/write commands on a valid/ready command channel and issues one bus cycle per command. It returns the read data or write completion on a valid/ready response channel. The block is used both as the on-chip bring-up/LA-driven host and as the bench driver for the wrapper.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in a bus cycle without ack before abort. Range 1..65535. Used only with the timeout feature.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when valid and ready are both high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lanes.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data (0 for writes or errors).
- rsp_err_o  out  1  1 = bus cycle aborted by timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control.
- wbm_sel_o  out  4  byte select.
- wbm_adr_o, wbm_dat_o  out  32 each  address and write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, register we/adr/dat/sel into the command register and go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; wbm_we/sel/adr/dat_o driven from the command register.
  - On wbm_ack_i: capture wbm_dat_i if read, else capture 0. Set err = 0 and go to RESP.
- RESP:
  - rsp_valid_o = 1 and the captured data/err are held stable.
  - On rsp_ready_i, go to IDLE.
- cmd_ready_o = 0 in BUS and RESP. Only one transaction is ever outstanding.
- wbm_cyc_o and wbm_stb_o are always equal; no block transfers and no pipelined mode.
- wbm_dat_o is driven for reads too (value don't-care, holds cmd_dat_i).
- Reset values: cmd_ready_o = 1 (IDLE); rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; rsp_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o = 0.
- Reset mid-transaction: the FSM goes to IDLE at the sampling edge, cyc/stb are low the next cycle, and any pending response is discarded.
- An ack arriving outside BUS is ignored.

## Timing
- Command accepted at edge E0. cyc/stb are high from E0 through the edge where ack is sampled (Ea ≥ E1), then low in the following cycle.
- rsp_valid_o rises after Ea. Minimum command-to-response latency is 2 cycles (ack on the first stb cycle).
- With rsp_ready_i tied high, RESP lasts 1 cycle, so back-to-back throughput is one transaction per 3 cycles minimum.
- cmd_ready_o is a pure state decode, with no combinational path from cmd_valid_i.
- Wishbone outputs are registered or a state decode; nothing is combinational from wbm_ack_i.

## Configuration
- WB_HOST_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - On the cycle where the count equals TIMEOUT_CYCLES-1 and no ack is present: drop cyc/stb, go to RESP with rsp_err_o = 1 and rsp_dat_o = 0.
  - An ack in that same cycle wins: normal response, err = 0.
- Not defined: BUS waits indefinitely for ack, rsp_err_o is tied 0, and no counter logic is present.

## Structure
- Package wb_host_pkg holds:
  - state enum (IDLE, BUS, RESP);
  - command-register struct (we, adr, dat, sel);
  - localparam WB_AW = 32, WB_DW = 32, WB_SELW = 4;
  - timeout counter width.
- Sub-module wb_host_timer is the timeout counter with clear/enable/expired ports. It is instantiated only under WB_HOST_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x30000004 <= 0xDEADBEEF, sel 0xF, slave acks on the first stb cycle → wbm_we_o = 1 and the address/data match on the bus; rsp_valid_o 2 cycles after accept with err = 0 and dat = 0.
- Read 0x30000000, slave acks after 3 wait cycles with 0x12345678 → stb high for 4 cycles, rsp_dat_o = 0x12345678, cmd_ready_o low throughout.
- Back-to-back: cmd_valid held high for 4 commands with rsp_ready_i = 1 and 0-wait ack → accepts spaced exactly 3 cycles apart, responses in order.
- Backpressure: rsp_ready_i low for 5 cycles → rsp_valid/dat/err stable, no new command accepted, no bus activity.
- Timeout (macro defined, TIMEOUT_CYCLES = 8), slave never acks → cyc low after 8 stb cycles, rsp_err_o = 1, rsp_dat_o = 0. Repeat with ack on cycle 8 → err = 0.
- Assert wb_rst_i during BUS → cyc/stb are 0 the following cycle, no rsp_valid_o, cmd_ready_o = 1 after release.
